uart_ram_arb: RTL and testbench

UART_RAM_ARB -- requirements
Module: uart_ram_arb

---
 rtl/uart_ram_arb_if.sv | 42 ++++
 rtl/uart_ram_arb.sv | 193 +++++++++++++++++++
 tb/tb_uart_ram_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ram_arb_if.sv
// ============================================================================
// Module  : uart_ram_arb_if
// Purpose : One master-side port of the RAM arbiter. It carries the request
//           and the response of a single master.
// Ports   : req    - access request (held until gnt)
//           we     - byte write enables, 4'b0000 = read
//           addr   - access address
//           wdata  - write data
//           lock   - keep ownership after this access
//           gnt    - access accepted this cycle
//           rvalid - read data valid (one cycle after a read grant)
//           rdata  - read data
// Modports: master (requester side), slave (arbiter side)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_ram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic [3:0]            we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  lock;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/uart_ram_arb.sv
// ============================================================================
// Module  : uart_ram_arb
// Purpose : Two-master arbiter in front of a single-port RAM. m0 is the AXI
//           bridge side and m1 is the debug engine. Ties go round-robin.
//           A master may lock ownership across accesses. A lock held for
//           LOCK_MAX cycles is broken and flagged on lock_err.
// Ports   : aclk      - clock, rising edge
//           aresetn   - asynchronous active-low reset
//           m0, m1    - master ports (uart_ram_arb_if.slave)
//           ram_ren   - slave read enable
//           ram_raddr - slave read address
//           ram_wen   - slave byte write enables
//           ram_waddr - slave write address
//           ram_wdata - slave write data
//           ram_rdata - slave read data, one cycle after ram_ren
//           lock_err  - sticky: a lock was forcibly broken
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_ram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  wire logic                  aclk,
  input  wire logic                  aresetn,
  uart_ram_arb_if.slave              m0,
  uart_ram_arb_if.slave              m1,
  output logic                       ram_ren,
  output logic [ADDR_WIDTH-1:0]      ram_raddr,
  output logic [3:0]                 ram_wen,
  output logic [ADDR_WIDTH-1:0]      ram_waddr,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  input  wire logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                       lock_err
);

  // LOCK_MAX never exceeds 255, so an 8-bit counter is always enough.
  localparam int             c_CNT_W     = 8;
  localparam [c_CNT_W-1:0]   c_LOCK_LAST = c_CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t               state_q,    state_d;
  logic                 prio_q,     prio_d;     // 1: m1 wins the next tie
  logic [c_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                 lock_err_q, lock_err_d;
  logic                 rvalid0_q,  rvalid0_d;
  logic                 rvalid1_q,  rvalid1_d;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any_gnt;
  logic                  w_sel_lock;
  logic [3:0]            w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Grant decision and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = lock_err_q;

    // Grants are gated by reset so that every output reads 0 while the
    // reset is active, even if masters are already requesting.
    if (aresetn) begin
      case (state_q)
        ST_IDLE: begin
          if (m0.req && m1.req) begin
            w_gnt0 = ~prio_q;
            w_gnt1 = prio_q;
          end else begin
            w_gnt0 = m0.req;
            w_gnt1 = m1.req;
          end
        end
        ST_OWN0: w_gnt0 = m0.req;
        ST_OWN1: w_gnt1 = m1.req;
        default: begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
        end
      endcase
    end

    w_any_gnt  = w_gnt0 | w_gnt1;
    w_sel_lock = w_gnt1 ? m1.lock : m0.lock;

    // The master just served loses the next tie.
    if (w_any_gnt) begin
      prio_d = w_gnt0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_any_gnt && w_sel_lock) begin
          state_d    = w_gnt1 ? ST_OWN1 : ST_OWN0;
          lock_cnt_d = '0;
        end
      end
      ST_OWN0, ST_OWN1: begin
        // In an owned state only the owner can be granted.
        // A voluntary release in the final cycle counts as a normal release.
        if (w_any_gnt && !w_sel_lock) begin
          state_d = ST_IDLE;
        end else if (lock_cnt_q == c_LOCK_LAST) begin
          state_d    = ST_IDLE;
          lock_err_d = 1'b1;
          prio_d     = (state_q == ST_OWN0);
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slave-side datapath: the granted master drives the RAM in the grant cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_we    = w_gnt1 ? m1.we    : m0.we;
    w_sel_addr  = w_gnt1 ? m1.addr  : m0.addr;
    w_sel_wdata = w_gnt1 ? m1.wdata : m0.wdata;

    ram_ren   = 1'b0;
    ram_raddr = '0;
    ram_wen   = 4'b0000;
    ram_waddr = '0;
    ram_wdata = '0;

    if (w_any_gnt) begin
      if (w_sel_we == 4'b0000) begin
        ram_ren   = 1'b1;
        ram_raddr = w_sel_addr;
      end else begin
        ram_wen   = w_sel_we;
        ram_waddr = w_sel_addr;
        ram_wdata = w_sel_wdata;
      end
    end

    // Read data returns exactly one cycle later. The return goes to the
    // master that issued the read.
    rvalid0_d = w_gnt0 && (m0.we == 4'b0000);
    rvalid1_d = w_gnt1 && (m1.we == 4'b0000);
  end

  assign m0.gnt    = w_gnt0;
  assign m1.gnt    = w_gnt1;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rvalid0_q ? ram_rdata : '0;
  assign m1.rdata  = rvalid1_q ? ram_rdata : '0;
  assign lock_err  = lock_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_ram_arb.sv
// ============================================================================
// Module  : tb_uart_ram_arb
// Purpose : Self-checking bench for uart_ram_arb (LOCK_MAX = 4). Directed
//           master traffic drives a small RAM. An ownership/queue model
//           predicts every output at the falling edge. Literal expectations
//           pin the key scenarios.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_ram_arb;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LM = 4;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  uart_ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_if ();
  uart_ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_if ();

  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          lock_err;

  uart_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .lock_err  (lock_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial RAM contents, shared by the stimulus RAM and by the model.
  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 2) return 32'h0000_0041;
    return 32'hA000_0000 + DW'(i);
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus RAM: 16 words, one-cycle read latency, byte writes
  // --------------------------------------------------------------------------
  logic [DW-1:0] ram_mem [16];
  initial for (int i = 0; i < 16; i++) ram_mem[i] = init_word(i);

  always @(posedge aclk) begin
    if (ram_ren) ram_rdata <= ram_mem[ram_raddr[5:2]];
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) ram_mem[ram_waddr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  // --------------------------------------------------------------------------
  // Behavioural model: owner / lock age / tie winner / pending returns
  // --------------------------------------------------------------------------
  int            owner;        // -1 none, else owning master
  int            age;          // cycles already spent under the lock
  int            tie;          // master that wins the next tie
  bit            err;
  bit            pend_v [2];
  logic [DW-1:0] pend_d;
  logic [DW-1:0] mdl_mem [16];

  initial begin
    owner = -1; age = 0; tie = 0; err = 1'b0;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0; pend_d = '0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = init_word(i);
  end

  always @(negedge aclk) begin : compare
    bit            r  [2];
    bit            lk [2];
    logic [3:0]    we [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    bit            nv [2];
    logic [DW-1:0] nd;
    int            g;
    r[0] = m0_if.req;  lk[0] = m0_if.lock; we[0] = m0_if.we; ad[0] = m0_if.addr; wd[0] = m0_if.wdata;
    r[1] = m1_if.req;  lk[1] = m1_if.lock; we[1] = m1_if.we; ad[1] = m1_if.addr; wd[1] = m1_if.wdata;
    if (!aresetn) begin
      check("rst m0_gnt",    m0_if.gnt,    0);
      check("rst m1_gnt",    m1_if.gnt,    0);
      check("rst m0_rvalid", m0_if.rvalid, 0);
      check("rst m1_rvalid", m1_if.rvalid, 0);
      check("rst m0_rdata",  m0_if.rdata,  0);
      check("rst m1_rdata",  m1_if.rdata,  0);
      check("rst ram_ren",   ram_ren,      0);
      check("rst ram_wen",   ram_wen,      0);
      check("rst lock_err",  lock_err,     0);
      owner = -1; age = 0; tie = 0; err = 1'b0;
      pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    end else begin
      g = -1;
      if (owner < 0) begin
        if (r[0] && r[1]) g = tie;
        else if (r[0])    g = 0;
        else if (r[1])    g = 1;
      end else if (r[owner]) begin
        g = owner;
      end
      check("m0_gnt",    m0_if.gnt,    (g == 0));
      check("m1_gnt",    m1_if.gnt,    (g == 1));
      check("m0_rvalid", m0_if.rvalid, pend_v[0]);
      check("m1_rvalid", m1_if.rvalid, pend_v[1]);
      if (pend_v[0]) check("m0_rdata", m0_if.rdata, pend_d);
      if (pend_v[1]) check("m1_rdata", m1_if.rdata, pend_d);
      check("lock_err", lock_err, err);

      nv[0] = 1'b0; nv[1] = 1'b0; nd = '0;
      if (g >= 0 && we[g] == 4'b0000) begin
        check("ram_ren",   ram_ren,   1);
        check("ram_wen",   ram_wen,   0);
        check("ram_raddr", ram_raddr, ad[g]);
        nv[g] = 1'b1;
        nd    = mdl_mem[ad[g][5:2]];
      end else if (g >= 0) begin
        check("ram_ren",   ram_ren,   0);
        check("ram_wen",   ram_wen,   we[g]);
        check("ram_waddr", ram_waddr, ad[g]);
        check("ram_wdata", ram_wdata, wd[g]);
        for (int b = 0; b < 4; b++)
          if (we[g][b]) mdl_mem[ad[g][5:2]][8*b +: 8] = wd[g][8*b +: 8];
      end else begin
        check("ram_ren idle", ram_ren, 0);
        check("ram_wen idle", ram_wen, 0);
      end
      pend_v[0] = nv[0]; pend_v[1] = nv[1]; pend_d = nd;

      if (g >= 0) tie = 1 - g;
      if (owner < 0) begin
        if (g >= 0 && lk[g]) begin owner = g; age = 0; end
      end else if (g == owner && !lk[g]) begin
        owner = -1;
      end else if (age + 1 >= LM) begin
        tie = 1 - owner; owner = -1; err = 1'b1;
      end else begin
        age++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // --------------------------------------------------------------------------
  task automatic set_m(input int m, input bit req, input logic [3:0] we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd, input bit lock);
    if (m == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wd; m0_if.lock = lock;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wd; m1_if.lock = lock;
    end
  endtask

  task automatic next_cycle();
    @(posedge aclk); #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Requests during reset must not produce grants.
    set_m(0, 1, 4'h0, 32'h8, 32'h0, 1'b0);
    set_m(1, 1, 4'h0, 32'hC, 32'h0, 1'b0);
    aresetn = 1'b0;
    next_cycle(); next_cycle();
    mid();
    check("L rst m0_gnt", m0_if.gnt, 0);
    check("L rst ram_ren", ram_ren, 0);
    next_cycle();
    aresetn = 1'b1;

    // First tie after reset goes to m0, then m1.
    mid();
    check("L tie0 m0_gnt", m0_if.gnt, 1);
    check("L tie0 m1_gnt", m1_if.gnt, 0);
    next_cycle();
    set_m(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    check("L tie1 m1_gnt", m1_if.gnt, 1);
    next_cycle();
    set_m(1, 0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Single read by m0 of 0x8.
    next_cycle();
    set_m(0, 1, 4'h0, 32'h8, 32'h0, 1'b0);
    mid();
    check("L rd m0_gnt",    m0_if.gnt, 1);
    check("L rd ram_ren",   ram_ren,   1);
    check("L rd ram_raddr", ram_raddr, 32'h8);
    next_cycle();
    set_m(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    check("L rd m0_rvalid", m0_if.rvalid, 1);
    check("L rd m0_rdata",  m0_if.rdata,  32'h41);
    check("L rd m1_rvalid", m1_if.rvalid, 0);

    // Write then read of the same address in consecutive cycles.
    next_cycle();
    set_m(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
    mid();
    check("L wr ram_wen", ram_wen, 4'hF);
    next_cycle();
    set_m(0, 1, 4'h0, 32'h10, 32'h0, 1'b0);
    mid();
    check("L raw ram_ren", ram_ren, 1);
    next_cycle();
    set_m(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1, 4'b0011, 32'h10, 32'h0000_1234, 1'b0);
    mid();
    check("L raw m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    next_cycle();
    set_m(1, 1, 4'h0, 32'h10, 32'h0, 1'b0);
    next_cycle();
    set_m(1, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    check("L bytewr m1_rdata", m1_if.rdata, 32'hDEAD_1234);

    // Continuous contention: grants alternate, returns routed to issuer.
    next_cycle();
    set_m(0, 1, 4'h0, 32'h8, 32'h0, 1'b0);
    set_m(1, 1, 4'h0, 32'hC, 32'h0, 1'b0);
    mid();
    check("L alt0 m0_gnt", m0_if.gnt, 1);
    next_cycle(); mid();
    check("L alt1 m1_gnt",    m1_if.gnt,    1);
    check("L alt1 m0_rdata",  m0_if.rdata,  32'h41);
    next_cycle(); mid();
    check("L alt2 m0_gnt",    m0_if.gnt,    1);
    check("L alt2 m1_rdata",  m1_if.rdata,  32'hA000_0003);
    repeat (3) next_cycle();
    set_m(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    set_m(1, 0, 4'h0, 32'h0, 32'h0, 1'b0);

    // m1 locked write, then unlocked read, while m0 waits.
    next_cycle();
    set_m(1, 1, 4'hF, 32'h4, 32'hCAFE_F00D, 1'b1);
    mid();
    check("L lk m1_gnt", m1_if.gnt, 1);
    next_cycle();
    set_m(1, 1, 4'h0, 32'h4, 32'h0, 1'b0);
    set_m(0, 1, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    check("L lk m0_gnt blocked", m0_if.gnt, 0);
    check("L lk m1_gnt unlock",  m1_if.gnt, 1);
    next_cycle();
    set_m(1, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    check("L lk m0_gnt after", m0_if.gnt,   1);
    check("L lk m1_rdata",     m1_if.rdata, 32'hCAFE_F00D);
    next_cycle();
    set_m(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);

    // m0 holds the lock past LOCK_MAX while m1 waits.
    next_cycle();
    set_m(0, 1, 4'h0, 32'h8, 32'h0, 1'b1);
    mid();
    check("L brk m0_gnt entry", m0_if.gnt, 1);
    next_cycle();
    set_m(1, 1, 4'h0, 32'hC, 32'h0, 1'b0);
    mid();
    check("L brk m1_gnt held", m1_if.gnt, 0);
    next_cycle(); next_cycle(); next_cycle();
    mid();
    check("L brk lock_err before", lock_err,  0);
    check("L brk m0_gnt last",     m0_if.gnt, 1);
    next_cycle();
    mid();
    check("L brk lock_err set", lock_err,     1);
    check("L brk m1_gnt",       m1_if.gnt,    1);
    check("L brk m0_rvalid",    m0_if.rvalid, 1);
    next_cycle();
    set_m(1, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    set_m(0, 1, 4'h0, 32'h8, 32'h0, 1'b0);
    mid();
    check("L brk lock_err sticky", lock_err, 1);
    next_cycle();
    set_m(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);

    // Reset right after an m1 read grant: the return is lost.
    next_cycle();
    set_m(1, 1, 4'h0, 32'h8, 32'h0, 1'b0);
    mid();
    check("L rr m1_gnt", m1_if.gnt, 1);
    next_cycle();
    aresetn = 1'b0;
    set_m(0, 1, 4'h0, 32'hC, 32'h0, 1'b0);
    mid();
    check("L rr m1_rvalid", m1_if.rvalid, 0);
    check("L rr lock_err",  lock_err,     0);
    next_cycle();
    next_cycle();
    aresetn = 1'b1;
    mid();
    check("L rr tie m0_gnt",  m0_if.gnt,    1);
    check("L rr tie m1_gnt",  m1_if.gnt,    0);
    check("L rr m1_rvalid2",  m1_if.rvalid, 0);
    next_cycle();
    mid();
    check("L rr m1_gnt next", m1_if.gnt,   1);
    check("L rr m0_rdata",    m0_if.rdata, 32'hA000_0003);
    next_cycle();
    set_m(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    set_m(1, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    next_cycle(); next_cycle();
    mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
